// File: rtl/burst_arb_mux_4_pkg.sv
// Shared types and constants for the 4-source burst arbiter/mux.
package burst_arb_mux_4_pkg;

    localparam int NPORT = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/burst_arb_mux_4_rr_pick.sv
// Combinational 4-way rotating-priority picker; the source just after
// 'last' wins first and 'last' itself is considered last.
module rr_pick_4
    import burst_arb_mux_4_pkg::*;
(
    input  logic [NPORT-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] cand;

    // Walk from lowest to highest priority so the highest-priority hit overwrites.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = NPORT; k >= 1; k--) begin
            cand = last + IDX_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/burst_arb_mux_4.sv
// Four-source packet arbiter/mux: grants one source for a whole packet,
// rotating priority between packets, with a beat limit that forces termination.
module burst_arb_mux_4
    import burst_arb_mux_4_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int MAX_BEATS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPORT-1:0]        s_valid,
    input  logic [NPORT*DATA_W-1:0] s_data,
    input  logic [NPORT-1:0]        s_last,
    output logic [NPORT-1:0]        s_ready,
    output logic                    m_valid,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    output logic [IDX_W-1:0]        m_src,
    input  logic                    m_ready,
    output logic                    err_overlong
);

    localparam int CNT_W = $clog2(MAX_BEATS + 1);

    state_t           state;
    logic [IDX_W-1:0] gnt;
    logic [IDX_W-1:0] last_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [CNT_W-1:0] beat_cnt;
    logic             force_last;
    logic             beat_done;

    rr_pick_4 u_pick (
        .req  (s_valid),
        .last (last_gnt),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // beat_cnt counts completed beats, so this flags the MAX_BEATS-th beat itself.
    assign force_last = (beat_cnt == CNT_W'(MAX_BEATS - 1));

    always_comb begin
        m_valid = 1'b0;
        m_data  = '0;
        m_last  = 1'b0;
        s_ready = '0;
        if (state == XFER) begin
            m_valid      = s_valid[gnt];
            m_data       = s_data[int'(gnt)*DATA_W +: DATA_W];
            m_last       = s_last[gnt] | force_last;
            s_ready[gnt] = m_ready;
        end
    end

    assign beat_done = m_valid & m_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            gnt          <= '0;
            m_src        <= '0;
            last_gnt     <= IDX_W'(NPORT - 1);
            beat_cnt     <= '0;
            err_overlong <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt   <= pick_idx;
                        m_src <= pick_idx;
                        state <= XFER;
                    end
                end
                XFER: begin
                    // A stalled source keeps the grant; only a completed last beat releases it.
                    if (beat_done) begin
                        if (m_last) begin
                            state    <= IDLE;
                            last_gnt <= gnt;
                            beat_cnt <= '0;
                            if (force_last && !s_last[gnt]) begin
                                err_overlong <= 1'b1;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_arb_mux_4.sv
// Scoreboard bench for burst_arb_mux_4: per-source packet drivers, expected
// beats queued in arbitration order and popped on each merged transfer.
module tb_burst_arb_mux_4;

    localparam int DW = 16;

    typedef struct {
        logic [1:0]    src;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    s_valid = '0;
    logic [4*DW-1:0] s_data = '0;
    logic [3:0]    s_last = '0;
    logic          m_ready = 1'b1;

    logic [3:0]    s_ready;
    logic          m_valid, m_last, err_overlong;
    logic [DW-1:0] m_data;
    logic [1:0]    m_src;

    logic [3:0]    o_s_ready;
    logic          o_m_valid, o_m_last, o_err;
    logic [DW-1:0] o_m_data;
    logic [1:0]    o_m_src;

    burst_arb_mux_4 #(.DATA_W(DW), .MAX_BEATS(256)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
        .m_src(m_src), .m_ready(m_ready), .err_overlong(err_overlong)
    );

    // Short beat limit instance, sharing the same stimulus, for the overlong case.
    burst_arb_mux_4 #(.DATA_W(DW), .MAX_BEATS(4)) dut_ovl (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(o_s_ready), .m_valid(o_m_valid), .m_data(o_m_data), .m_last(o_m_last),
        .m_src(o_m_src), .m_ready(m_ready), .err_overlong(o_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    beat_t       exp_q[$];
    int          rem[4], pk[4], plen[4], bidx[4];
    logic [DW-1:0] base[4];
    logic [3:0]  no_last = '0;
    logic [3:0]  acc = '0;
    logic        rst_nxt = 1'b1;
    logic        m_ready_nxt = 1'b1;
    bit          mon_en = 1'b1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic pushBeat(input logic [1:0] s, input logic [DW-1:0] d, input logic l);
        beat_t e;
        e.src  = s;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    // One clock: account accepted beats, drive next inputs, then sample settled outputs.
    task automatic applyStimulus();
        beat_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                bidx[i]++;
                rem[i]--;
                if (rem[i] == 0 && pk[i] > 0) begin
                    pk[i]--;
                    rem[i] = plen[i];
                end
            end
        end
        rst     = rst_nxt;
        m_ready = m_ready_nxt;
        for (int i = 0; i < 4; i++) begin
            s_valid[i]          = (rem[i] > 0);
            s_data[i*DW +: DW]  = base[i] + DW'(bidx[i]);
            s_last[i]           = (rem[i] == 1) && !no_last[i];
        end
        #2;
        acc = rst ? 4'b0000 : (s_valid & s_ready);
        if (mon_en && !rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("sb_unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("sb_src", m_src, e.src);
                checkOutput("sb_data", m_data, e.data);
                checkOutput("sb_last", m_last, e.last);
            end
        end
    endtask

    task automatic resetPhase();
        rst_nxt     = 1'b1;
        m_ready_nxt = 1'b1;
        applyStimulus();
        applyStimulus();
        for (int i = 0; i < 4; i++) begin
            rem[i]  = 0;
            pk[i]   = 0;
            plen[i] = 0;
            bidx[i] = 0;
            base[i] = '0;
        end
        no_last = '0;
        acc     = '0;
        exp_q.delete();
        rst_nxt = 1'b0;
    endtask

    task automatic drainQueue(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, exp_q.size(), 32'd0);
    endtask

    initial begin
        int xfer_cycles;
        bit started;

        // Reset state
        resetPhase();
        checkOutput("rst_m_valid", m_valid, 1'b0);
        checkOutput("rst_s_ready", s_ready, 4'b0000);
        checkOutput("rst_m_src", m_src, 2'd0);
        checkOutput("rst_m_data", m_data, 16'h0000);
        checkOutput("rst_err", err_overlong, 1'b0);
        checkOutput("rst_err_ovl", o_err, 1'b0);

        // All four requesting single-beat packets: 0,1,2,3,0 with an idle cycle between
        for (int i = 0; i < 4; i++) begin
            base[i] = DW'(16'h0100 * i);
            plen[i] = 1;
            rem[i]  = 1;
        end
        pk[0] = 1;
        pushBeat(2'd0, 16'h0000, 1'b1);
        pushBeat(2'd1, 16'h0100, 1'b1);
        pushBeat(2'd2, 16'h0200, 1'b1);
        pushBeat(2'd3, 16'h0300, 1'b1);
        pushBeat(2'd0, 16'h0001, 1'b1);
        for (int k = 0; k <= 10; k++) begin
            applyStimulus();
            checkOutput("rr_valid_pattern", m_valid, (k % 2 == 1) && (k < 10));
        end
        checkOutput("rr_drain", exp_q.size(), 32'd0);

        // Source 2 five-beat packet; source 1 arrives mid-packet and must wait
        resetPhase();
        base[2] = 16'h0020; plen[2] = 5; rem[2] = 5;
        base[1] = 16'h0031; plen[1] = 1;
        for (int b = 0; b < 5; b++) pushBeat(2'd2, DW'(16'h0020 + b), b == 4);
        pushBeat(2'd1, 16'h0031, 1'b1);
        started = 1'b0;
        for (int n = 0; n < 30 && exp_q.size() > 0; n++) begin
            if (!started && bidx[2] == 2) begin
                rem[1]  = 1;
                started = 1'b1;
            end
            applyStimulus();
            if (rem[2] > 0) checkOutput("hold_s_ready1", s_ready[1], 1'b0);
        end
        checkOutput("hold_src1_raised", started, 1'b1);
        checkOutput("hold_drain", exp_q.size(), 32'd0);

        // m_ready toggling during a 4-beat packet
        resetPhase();
        base[0] = 16'h00A0; plen[0] = 4; rem[0] = 4;
        for (int b = 0; b < 4; b++) pushBeat(2'd0, DW'(16'h00A0 + b), b == 3);
        xfer_cycles = 0;
        for (int k = 0; k < 20; k++) begin
            applyStimulus();
            if (m_valid) xfer_cycles++;
            m_ready_nxt = ~m_ready_nxt;
        end
        m_ready_nxt = 1'b1;
        checkOutput("stall_cycles", xfer_cycles, 32'd8);
        checkOutput("stall_drain", exp_q.size(), 32'd0);

        // Overlong packet against the 4-beat-limit instance
        resetPhase();
        mon_en = 1'b0;
        base[3] = 16'h0300; plen[3] = 100; rem[3] = 100; no_last[3] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            if (k >= 1 && k <= 4) begin
                checkOutput("ovl_valid", o_m_valid, 1'b1);
                checkOutput("ovl_src", o_m_src, 2'd3);
                checkOutput("ovl_data", o_m_data, 32'h0300 + k - 1);
                checkOutput("ovl_last", o_m_last, k == 4);
                checkOutput("ovl_err_early", o_err, 1'b0);
            end
            if (k == 5) begin
                checkOutput("ovl_err_set", o_err, 1'b1);
                checkOutput("ovl_idle", o_m_valid, 1'b0);
            end
            if (k == 7) begin
                checkOutput("ovl_err_sticky", o_err, 1'b1);
                checkOutput("ovl_main_no_err", err_overlong, 1'b0);
            end
        end
        resetPhase();
        mon_en = 1'b1;
        checkOutput("ovl_err_clr", o_err, 1'b0);

        // Reset mid-packet from source 1, then a fresh request from source 1
        base[1] = 16'h0040; plen[1] = 4; rem[1] = 4;
        pushBeat(2'd1, 16'h0040, 1'b0);
        pushBeat(2'd1, 16'h0041, 1'b0);
        applyStimulus();
        applyStimulus();
        applyStimulus();
        checkOutput("abort_beat1_data", m_data, 16'h0041);
        rst_nxt = 1'b1;
        applyStimulus();
        rst_nxt = 1'b0;
        rem[1] = 1; plen[1] = 1; bidx[1] = 0; base[1] = 16'h0050;
        pushBeat(2'd1, 16'h0050, 1'b1);
        applyStimulus();
        checkOutput("abort_valid_after_rst", m_valid, 1'b0);
        checkOutput("abort_ready_after_rst", s_ready, 4'b0000);
        applyStimulus();
        checkOutput("abort_regrant_valid", m_valid, 1'b1);
        checkOutput("abort_regrant_src", m_src, 2'd1);
        drainQueue("abort_drain", 10);

        // Sole requester source 3, three 2-beat packets
        resetPhase();
        base[3] = 16'h0070; plen[3] = 2; rem[3] = 2; pk[3] = 2;
        for (int b = 0; b < 6; b++) pushBeat(2'd3, DW'(16'h0070 + b), b % 2 == 1);
        drainQueue("sole_drain", 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/burst_arb_mux_4.md
BURST_ARB_MUX_4 -- requirements
Module: burst_arb_mux_4

Interface
REQ-001 SHALL have parameter DATA_W, default 64, giving the data width per port.
REQ-002 SHALL have parameter MAX_BEATS, default 256, giving the beat limit per packet (range 2..65535).
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic rises on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port s_valid, input, 4 bits: per-source beat valid.
REQ-006 SHALL have port s_data, input, 4*DATA_W bits: source i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port s_last, input, 4 bits: per-source end-of-packet.
REQ-008 SHALL have port s_ready, output, 4 bits: per-source beat accept.
REQ-009 SHALL have port m_valid, output, 1 bit: merged beat valid.
REQ-010 SHALL have port m_data, output, DATA_W bits: merged data.
REQ-011 SHALL have port m_last, output, 1 bit: merged end-of-packet.
REQ-012 SHALL have port m_src, output, 2 bits: index of the granted source.
REQ-013 SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-014 SHALL have port err_overlong, output, 1 bit: sticky flag for forced packet termination.

Function
REQ-015 SHALL implement states IDLE and XFER.
REQ-016 In IDLE with any s_valid high, SHALL grant in that cycle and register gnt and m_src; SHALL enter XFER on the next cycle. Grant latency SHALL be 1 cycle from s_valid to m_valid.
REQ-017 Grant SHALL be rotating-priority: search order SHALL start at last_gnt+1 mod 4 and wrap; the last granted source SHALL have lowest priority.
REQ-018 In IDLE with s_valid == 0, SHALL stay in IDLE; gnt and last_gnt SHALL be unchanged.
REQ-019 In XFER, m_valid, m_data and m_last SHALL combinationally follow the granted source; s_ready[gnt] SHALL equal m_ready; all other s_ready bits SHALL be 0.
REQ-020 A beat SHALL transfer when m_valid and m_ready are both high; the beat counter SHALL increment per transfer.
REQ-021 A transfer with m_last=1 SHALL return the block to IDLE, set last_gnt=gnt and clear the beat counter. Back-to-back packets SHALL therefore have exactly one idle cycle between them.
REQ-022 Grant SHALL be held for the whole packet. A drop of the granted s_valid mid-packet SHALL only stall the transfer, not release the grant.
REQ-023 On the MAX_BEATS-th transfer without s_last, SHALL force m_last=1 on that beat, set err_overlong, and return to IDLE as in REQ-021.
REQ-024 When not in XFER, m_valid SHALL be 0 and s_ready SHALL be 4'b0000.
REQ-025 m_data SHALL be don't-care when m_valid is 0, but SHALL be driven 0 in IDLE.

Reset
REQ-026 On rst, state SHALL be IDLE, gnt=0, m_src=0, last_gnt=3 (so source 0 wins first), beat counter=0, err_overlong=0.
REQ-027 rst asserted mid-packet SHALL abort the packet immediately. No partial beat accounting SHALL survive.
REQ-028 err_overlong SHALL be cleared only by rst.

Structure
REQ-029 The shared package SHALL hold the state enum (IDLE, XFER), the port count constant NPORT=4, and the index width constant 2.
REQ-030 One sub-module, rr_pick_4, SHALL be a combinational 4-way rotating priority picker with inputs req[3:0] and last[1:0], and outputs any and idx[1:0].
REQ-031 The beat counter SHALL be sized $clog2(MAX_BEATS+1) bits.

Verification
REQ-032 Reset, then s_valid=4'b1111 with single-beat packets and m_ready=1 SHALL produce grant order 0,1,2,3,0 with one idle cycle between grants.
REQ-033 Source 2 sends a 5-beat packet while source 1 raises s_valid at beat 2: source 1 SHALL be granted only after source 2's last beat, and s_ready[1] SHALL stay 0 throughout.
REQ-034 m_ready toggling 1,0,1,0 during a 4-beat packet SHALL take 8 cycles; no beat SHALL be lost or duplicated, checked against data values 0xA0..0xA3.
REQ-035 With MAX_BEATS=4 and source 3 never asserting s_last: beat 4 SHALL show m_last=1, err_overlong=1 one cycle after it, and return to IDLE.
REQ-036 rst asserted at beat 2 of a packet from source 1 SHALL give m_valid=0 next cycle; a subsequent request from source 1 alone SHALL be granted with m_src=1.
REQ-037 s_valid=4'b1000 only, three packets in a row: source 3 SHALL be granted each time, since there is no starvation of the sole requester.
